// File: rtl/ipu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ipu_pkg
// Description : Shared types and constants for the grid-press interrupt
//               generator: request FSM states, coordinate width and the
//               default highest legal coordinate of the 3x3 board.
// Revision    : 1.0 - initial release
// ============================================================================
package ipu_pkg;

  // Width of a grid coordinate as delivered to the processor.
  localparam int unsigned c_coord_w = 4;

  // Highest legal cell index on a 3x3 board (cells 0..8).
  localparam logic [c_coord_w-1:0] c_max_coord_def = 4'd8;

  // Interrupt request sequencing.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } ipu_state_e;

endpackage
`default_nettype wire

// File: rtl/ipu_debounce.sv
`default_nettype none
// ============================================================================
// Module      : ipu_debounce
// Description : Level debouncer for the synchronized press button. The
//               output follows the input only once the input has disagreed
//               with it for DB_CYCLES consecutive clocks; any return to the
//               current level restarts the count.
// Revision    : 1.0 - initial release
// ============================================================================
module ipu_debounce
  import ipu_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sync,
  output logic o_level
);

  logic [15:0] r_cnt;
  logic        r_level;

  // Count consecutive disagreeing cycles; adopt the new level on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (i_sync != r_level) begin
      if (r_cnt == DB_CYCLES - 16'd1) begin
        r_level <= i_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/ipu_int_gen.sv
`default_nettype none
// ============================================================================
// Module      : ipu_int_gen
// Description : Turns grid button presses into a level interrupt for the
//               processor. Presses are synchronized, optionally debounced
//               (build with IPU_DEBOUNCE_EN), edge detected, range checked
//               and queued; a small FSM presents the queue head until it is
//               acknowledged, then forces one low GAP cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ipu_int_gen
  import ipu_pkg::*;
#(
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [15:0]           DB_CYCLES  = 16'd50000,
  parameter logic [c_coord_w-1:0]  MAX_COORD  = c_max_coord_def
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_raw,
  input  logic [c_coord_w-1:0] sel_coord,
  input  logic                 int_ack,
  output logic                 ipu_int,
  output logic [c_coord_w-1:0] grid_coord,
  output logic                 fifo_full,
  output logic [7:0]           drop_cnt
);

  localparam int unsigned c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

  // Button conditioning
  logic       r_sync1;
  logic       r_sync2;
  logic [1:0] r_sync_vld;
  logic       w_btn;
  logic       r_btn_d;
  logic       r_armed;
  logic       w_press;
  logic       r_press;
  logic [c_coord_w-1:0] r_press_coord;

  // Queue
  logic [c_coord_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_legal;
  logic                 w_push;
  logic                 w_drop;
  logic [7:0]           r_drop_cnt;

  // Request FSM
  ipu_state_e r_state;
  ipu_state_e w_state_nxt;

  // Two-flop synchronizer; r_sync_vld marks when r_sync2 holds a real sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sync_vld <= '0;
    end else begin
      r_sync1    <= btn_raw;
      r_sync2    <= r_sync1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
    end
  end

`ifdef IPU_DEBOUNCE_EN
  ipu_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .i_sync  (r_sync2),
    .o_level (w_btn)
  );
`else
  assign w_btn = r_sync2;

  // DB_CYCLES has no effect without the debouncer; referencing it keeps the
  // parameter list identical between the two builds.
  if (DB_CYCLES == 16'd0) begin : g_no_debounce
  end
`endif

  // A press needs a low level seen after reset, so a button held through
  // reset release is ignored until it is released and pressed again.
  assign w_press = w_btn & ~r_btn_d & r_armed;

  // Edge register, arming flag and the registered press with its coordinate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn_d       <= 1'b0;
      r_armed       <= 1'b0;
      r_press       <= 1'b0;
      r_press_coord <= '0;
    end else begin
      r_btn_d <= w_btn;
      if (r_sync_vld[1] && !r_sync2) begin
        r_armed <= 1'b1;
      end
      r_press <= w_press;
      if (w_press) begin
        r_press_coord <= sel_coord;
      end
    end
  end

  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);
  assign w_pop   = (r_state == REQ) && int_ack;
  assign w_legal = (r_press_coord <= MAX_COORD);
  // A simultaneous pop frees the head slot, so a full queue still accepts.
  assign w_push  = r_press && w_legal && (!w_full || w_pop);
  assign w_drop  = r_press && !w_push;

  // Queue storage; contents need no reset since occupancy guards them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_press_coord;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy tracks both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating count of rejected presses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and interrupt outputs; the head is only shown while requesting.
  always_comb begin
    w_state_nxt = r_state;
    ipu_int     = 1'b0;
    grid_coord  = '0;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        ipu_int    = 1'b1;
        grid_coord = r_mem[r_rd_ptr];
        if (int_ack) begin
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign fifo_full = w_full;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ipu_int_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ipu_int_gen
// Description : Self-checking bench for ipu_int_gen. A behavioural model of
//               press conditioning, queueing and request handshake is
//               stepped on every clock and compared with the outputs,
//               alongside directed scenarios and a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ipu_int_gen;

  localparam int DEPTH = 4;
  localparam int DB    = 8;
  localparam int MAXC  = 8;
`ifdef IPU_DEBOUNCE_EN
  localparam int LAT  = 5 + DB;
  localparam int HOLD = DB + 6;
`else
  localparam int LAT  = 5;
  localparam int HOLD = 4;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic [3:0] sel_coord;
  logic       int_ack;
  logic       ipu_int;
  logic [3:0] grid_coord;
  logic       fifo_full;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ipu_int_gen #(
    .FIFO_DEPTH (DEPTH),
    .DB_CYCLES  (16'd8),
    .MAX_COORD  (4'd8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .sel_coord  (sel_coord),
    .int_ack    (int_ack),
    .ipu_int    (ipu_int),
    .grid_coord (grid_coord),
    .fifo_full  (fifo_full),
    .drop_cnt   (drop_cnt)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int q[$];          // queued coordinates, head first
  bit m_int;         // interrupt currently requested
  bit m_hold;        // one extra forced-low cycle after an acknowledge
  int m_drop;
  bit m_pend_v;      // a press will attempt its push at the next edge
  int m_pend_c;
  bit m_rise_prev;   // conditioned button rose at the previous edge
  bit h1, h2, h1_ok, h2_ok;  // last two raw samples and whether post-reset
  bit m_armed;
  bit m_cond;
  int m_run;

  task automatic model_reset();
    q.delete();
    m_int = 0; m_hold = 0; m_drop = 0;
    m_pend_v = 0; m_pend_c = 0; m_rise_prev = 0;
    h1 = 0; h2 = 0; h1_ok = 0; h2_ok = 0;
    m_armed = 0; m_cond = 0; m_run = 0;
  endtask

  // Applies one clock edge using the inputs held before that edge.
  task automatic model_edge();
    int size_pre;
    bit pop;
    bit s_pre;
    bit s_ok;
    bit cond_old;
    if (rst) begin
      model_reset();
    end else begin
      size_pre = q.size();
      pop      = m_int && int_ack;
      s_pre    = h2;
      s_ok     = h2_ok;
      cond_old = m_cond;
      if (pop) void'(q.pop_front());
      if (m_pend_v) begin
        if (m_pend_c <= MAXC && (size_pre < DEPTH || pop)) q.push_back(m_pend_c);
        else if (m_drop < 255) m_drop++;
      end
      if (pop) begin
        m_int = 0; m_hold = 1;
      end else if (!m_int) begin
        if (m_hold) m_hold = 0;
        else if (size_pre > 0) m_int = 1;
      end
      m_pend_v = m_rise_prev;
      m_pend_c = int'(sel_coord);
      if (s_ok && !s_pre) m_armed = 1;
      h2 = h1; h2_ok = h1_ok; h1 = btn_raw; h1_ok = 1;
`ifdef IPU_DEBOUNCE_EN
      if (s_pre != m_cond) begin
        m_run++;
        if (m_run == DB) begin m_cond = s_pre; m_run = 0; end
      end else begin
        m_run = 0;
      end
`else
      m_cond = h2;
`endif
      m_rise_prev = m_cond && !cond_old && m_armed;
    end
  endtask

  task automatic tick();
    int exp_coord;
    @(posedge clk);
    model_edge();
    #1;
    exp_coord = (m_int && q.size() > 0) ? q[0] : 0;
    check_eq("ipu_int", int'(ipu_int), int'(m_int));
    check_eq("grid_coord", int'(grid_coord), exp_coord);
    check_eq("fifo_full", int'(fifo_full), int'(q.size() == DEPTH));
    check_eq("drop_cnt", int'(drop_cnt), m_drop);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    ticks(2);
  endtask

  task automatic press(input int coord);
    sel_coord = 4'(coord);
    btn_raw = 1'b1;
    ticks(HOLD);
    btn_raw = 1'b0;
    ticks(HOLD);
  endtask

  task automatic wait_int(output int low_cycles);
    low_cycles = 0;
    while (ipu_int !== 1'b1 && low_cycles < 300) begin
      tick();
      low_cycles++;
    end
    if (ipu_int !== 1'b1) check_eq("wait_int_timeout", int'(ipu_int), 1);
  endtask

  task automatic ack_take(output int coord);
    coord = int'(grid_coord);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check_eq("low_after_ack", int'(ipu_int), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int low;
    int got;
    int ok;
    int hold_left;
    int exp_order[4];

    model_reset();
    rst = 1'b1; btn_raw = 1'b0; int_ack = 1'b0; sel_coord = 4'd0;
    ticks(3);
    rst = 1'b0;
    check_eq("rst_ipu_int", int'(ipu_int), 0);
    check_eq("rst_grid", int'(grid_coord), 0);
    check_eq("rst_full", int'(fifo_full), 0);
    check_eq("rst_drop", int'(drop_cnt), 0);
    ticks(5);

`ifdef IPU_DEBOUNCE_EN
    // Bouncing input must be filtered out entirely.
    for (int seg = 0; seg < 10; seg++) begin
      btn_raw = (seg % 2 == 0);
      ticks(3);
    end
    check_eq("bounce_no_int", int'(ipu_int), 0);
`endif

    // Single press of cell 5: exact latency, held request, one-cycle ack.
    sel_coord = 4'd5;
    btn_raw = 1'b1;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      if (i == LAT - 1) check_eq("latency_pre", int'(ipu_int), 0);
      if (i == LAT) check_eq("latency", int'(ipu_int), 1);
    end
    btn_raw = 1'b0;
    ok = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ipu_int !== 1'b1 || grid_coord !== 4'd5) ok = 0;
    end
    check_eq("hold_coord5", ok, 1);
    ack_take(got);
    check_eq("ack_coord5", got, 5);
    ok = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ipu_int !== 1'b0) ok = 0;
    end
    check_eq("single_push_only", ok, 1);

    // Five presses into a depth-4 queue: one drop, ordered delivery.
    press(1); press(2); press(3); press(4); press(6);
    ticks(5);
    check_eq("overflow_full", int'(fifo_full), 1);
    check_eq("overflow_drop", int'(drop_cnt), 1);
    exp_order = '{1, 2, 3, 4};
    for (int i = 0; i < 4; i++) begin
      wait_int(low);
      if (i > 0) check_eq("gap_before_req", int'(low >= 1), 1);
      ack_take(got);
      check_eq("order", got, exp_order[i]);
    end
    ticks(10);
    check_eq("drained_int", int'(ipu_int), 0);

    // Illegal coordinate is dropped without an interrupt.
    do_reset();
    press(9);
    ticks(10);
    check_eq("illegal_drop", int'(drop_cnt), 1);
    check_eq("illegal_no_int", int'(ipu_int), 0);

    // Reset in the middle of a request with two entries queued.
    do_reset();
    press(3); press(7);
    check_eq("midrst_pre_int", int'(ipu_int), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_int", int'(ipu_int), 0);
    check_eq("midrst_full", int'(fifo_full), 0);
    check_eq("midrst_drop", int'(drop_cnt), 0);
    int_ack = 1'b1;
    ticks(2);
    int_ack = 1'b0;
    ticks(10);
    check_eq("midrst_stays_low", int'(ipu_int), 0);
    press(2);
    wait_int(low);
    ack_take(got);
    check_eq("midrst_fresh", got, 2);

    // Acknowledge coincides with a push into a full queue.
    do_reset();
    press(1); press(2); press(3); press(4);
    check_eq("full_before", int'(fifo_full), 1);
    sel_coord = 4'd7;
    btn_raw = 1'b1;
    low = 0;
    while (!m_pend_v && low < 60) begin tick(); low++; end
    check_eq("push_due_seen", int'(m_pend_v), 1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check_eq("pushpop_full", int'(fifo_full), 1);
    check_eq("pushpop_drop", int'(drop_cnt), 0);
    btn_raw = 1'b0;
    ticks(HOLD);
    exp_order = '{2, 3, 4, 7};
    for (int i = 0; i < 4; i++) begin
      wait_int(low);
      ack_take(got);
      check_eq("pushpop_order", got, exp_order[i]);
    end

    // Button held through reset release generates nothing until re-pressed.
    rst = 1'b1;
    btn_raw = 1'b1;
    ticks(2);
    rst = 1'b0;
    ticks(30);
    check_eq("held_rst_no_int", int'(ipu_int), 0);
    check_eq("held_rst_no_drop", int'(drop_cnt), 0);
    btn_raw = 1'b0;
    ticks(HOLD);
    press(4);
    wait_int(low);
    ack_take(got);
    check_eq("held_rst_repress", got, 4);

    // Randomized traffic against the model.
    do_reset();
    hold_left = 1;
    for (int i = 0; i < 600; i++) begin
      hold_left--;
      if (hold_left <= 0) begin
        btn_raw = ~btn_raw;
        hold_left = $urandom_range(1, HOLD * 2);
      end
      if ($urandom_range(0, 3) == 0) sel_coord = 4'($urandom_range(0, 15));
      int_ack = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 249) == 0);
      tick();
    end
    rst = 1'b0;
    int_ack = 1'b0;
    btn_raw = 1'b0;
    ticks(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
